// File: rtl/ram_arbiter_pkg.sv
// ============================================================================
// Module : ram_arb_defs (package)
// Brief  : Shared state encodings, widths and helpers for ram_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ram_arb_defs;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 8;
    localparam int LAT_W  = 3;
    localparam int STAT_W = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

    // Saturating increment for the per-requester access counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_if.sv
// ============================================================================
// Module : ram_arbiter_if
// Brief  : Requester handshakes plus RAM pins; slave = arbiter, master = env.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ram_arbiter_if #(
    parameter int AW = ram_arb_defs::DEF_AW,
    parameter int DW = ram_arb_defs::DEF_DW
);
    logic          req_0, we_0, ack_0;
    logic [AW-1:0] a_0;
    logic [DW-1:0] d_0, q_0;
    logic          req_1, we_1, ack_1;
    logic [AW-1:0] a_1;
    logic [DW-1:0] d_1, q_1;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_d, ram_q;
    logic          ram_re, ram_we;

    modport slave (
        input  req_0, we_0, a_0, d_0, req_1, we_1, a_1, d_1, ram_q,
        output ack_0, q_0, ack_1, q_1, ram_a, ram_d, ram_re, ram_we
    );

    modport master (
        output req_0, we_0, a_0, d_0, req_1, we_1, a_1, d_1, ram_q,
        input  ack_0, q_0, ack_1, q_1, ram_a, ram_d, ram_re, ram_we
    );
endinterface

`default_nettype wire

// File: rtl/ram_arbiter_rr_pick2.sv
// ============================================================================
// Module : rr_pick2
// Brief  : Combinational two-way round-robin picker; ties go to !last.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_idx
);
    assign gnt_valid = |req;
    assign gnt_idx   = (&req) ? ~last : req[1];
endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// Module : ram_arbiter
// Brief  : Round-robin arbiter/sequencer for a single-port sync RAM.
//          Define RAM_ARB_STATS_EN to add stat_0/stat_1 access counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_arbiter
    import ram_arb_defs::*;
#(
    parameter int RD_LAT = 1,
    parameter int AW     = DEF_AW,
    parameter int DW     = DEF_DW
) (
    input  logic                clk,
    input  logic                rst,
    ram_arbiter_if.slave        bus
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]   stat_0,
    output logic [STAT_W-1:0]   stat_1
`endif
);

    localparam logic [LAT_W-1:0] c_rd_lat = LAT_W'(RD_LAT);

    logic [1:0]       r_state;
    logic             r_gnt, r_last, r_we;
    logic [LAT_W-1:0] r_cnt;
    logic [AW-1:0]    r_ram_a;
    logic [DW-1:0]    r_ram_d;
    logic             r_ram_re, r_ram_we;
    logic             r_ack_0, r_ack_1;
    logic [DW-1:0]    r_q_0, r_q_1;

    logic             w_gnt_valid, w_gnt_idx, w_sel_we;

    rr_pick2 u_pick (
        .req       ({bus.req_1, bus.req_0}),
        .last      (r_last),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    assign w_sel_we = w_gnt_idx ? bus.we_1 : bus.we_0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_gnt    <= 1'b0;
            r_last   <= 1'b1;   // first tie after reset goes to requester 0
            r_we     <= 1'b0;
            r_cnt    <= '0;
            r_ram_a  <= '0;
            r_ram_d  <= '0;
            r_ram_re <= 1'b0;
            r_ram_we <= 1'b0;
            r_ack_0  <= 1'b0;
            r_ack_1  <= 1'b0;
            r_q_0    <= '0;
            r_q_1    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_gnt    <= w_gnt_idx;
                        r_last   <= w_gnt_idx;
                        r_we     <= w_sel_we;
                        r_ram_a  <= w_gnt_idx ? bus.a_1 : bus.a_0;
                        r_ram_d  <= w_gnt_idx ? bus.d_1 : bus.d_0;
                        r_ram_we <= w_sel_we;
                        r_ram_re <= ~w_sel_we;
                        r_state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_ram_we <= 1'b0;
                    r_ram_re <= 1'b0;
                    if (r_we) begin
                        r_ack_0 <= ~r_gnt;
                        r_ack_1 <= r_gnt;
                        r_state <= ST_ACK;
                    end else begin
                        r_cnt   <= c_rd_lat;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - LAT_W'(1);
                    // Counter hits zero on this edge: ram_q is valid now.
                    if (r_cnt <= LAT_W'(1)) begin
                        if (r_gnt) r_q_1 <= bus.ram_q;
                        else       r_q_0 <= bus.ram_q;
                        r_ack_0 <= ~r_gnt;
                        r_ack_1 <= r_gnt;
                        r_state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    r_ack_0 <= 1'b0;
                    r_ack_1 <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ack_0  = r_ack_0;
    assign bus.ack_1  = r_ack_1;
    assign bus.q_0    = r_q_0;
    assign bus.q_1    = r_q_1;
    assign bus.ram_a  = r_ram_a;
    assign bus.ram_d  = r_ram_d;
    assign bus.ram_re = r_ram_re;
    assign bus.ram_we = r_ram_we;

`ifdef RAM_ARB_STATS_EN
    logic [STAT_W-1:0] r_stat_0, r_stat_1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_0 <= '0;
            r_stat_1 <= '0;
        end else if (r_state == ST_ACK) begin
            if (r_gnt) r_stat_1 <= sat_inc(r_stat_1);
            else       r_stat_0 <= sat_inc(r_stat_0);
        end
    end

    assign stat_0 = r_stat_0;
    assign stat_1 = r_stat_1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// Module : tb_ram_arbiter
// Brief  : Self-checking bench for ram_arbiter with a behavioural RAM and
//          reference model; honours RAM_ARB_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

    localparam int RD_LAT = 3;
    localparam int AW     = 16;
    localparam int DW     = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef RAM_ARB_STATS_EN
    logic [15:0] stat_0, stat_1;
`endif

    ram_arbiter #(.RD_LAT(RD_LAT), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef RAM_ARB_STATS_EN
        ,
        .stat_0 (stat_0),
        .stat_1 (stat_1)
`endif
    );

    // Behavioural RAM: q appears RD_LAT edges after the issue edge; idle
    // pipeline slots carry junk so an early or late capture is visible.
    logic [DW-1:0] ram_mem [0:65535];
    logic [DW-1:0] pipe [RD_LAT];

    initial begin
        for (int i = 0; i < 65536; i++) ram_mem[i] = '0;
        for (int i = 0; i < RD_LAT; i++) pipe[i] = '0;
    end

    always @(posedge clk) begin
        if (bus.ram_we) ram_mem[bus.ram_a] <= bus.ram_d;
        pipe[0] <= bus.ram_re ? ram_mem[bus.ram_a] : 8'($urandom);
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.ram_q = pipe[RD_LAT-1];

    // Reference model state
    int            n_checks = 0;
    int            n_err    = 0;
    int            tb_last;
    logic [DW-1:0] ref_q [2];
    int            ref_stat [2];
    logic [DW-1:0] ref_mem [int];

    function automatic logic [DW-1:0] ref_rd(input int addr);
        return ref_mem.exists(addr) ? ref_mem[addr] : '0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_stats(input string tag);
`ifdef RAM_ARB_STATS_EN
        check({tag, "_stat_0"}, 32'(stat_0), 32'(ref_stat[0]));
        check({tag, "_stat_1"}, 32'(stat_1), 32'(ref_stat[1]));
`else
        n_checks = n_checks + 0;
`endif
    endtask

    task automatic set_req(input int idx, input logic w, input logic [15:0] addr, input logic [7:0] dat);
        if (idx == 0) begin
            bus.we_0 = w; bus.a_0 = addr; bus.d_0 = dat; bus.req_0 = 1'b1;
        end else begin
            bus.we_1 = w; bus.a_1 = addr; bus.d_1 = dat; bus.req_1 = 1'b1;
        end
    endtask

    // One access by a single requester with the arbiter idle.
    task automatic do_access(input int idx, input logic w, input logic [15:0] addr, input logic [7:0] dat);
        int cyc, nwe, nre, other;
        logic got;
        logic [15:0] sa;
        logic [7:0]  sd;
        cyc = 0; nwe = 0; nre = 0; other = 0; got = 1'b0; sa = '0; sd = '0;
        @(posedge clk); #1;
        set_req(idx, w, addr, dat);
        while (!got && cyc < 20) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            check("strobe_excl", 32'(bus.ram_re & bus.ram_we), 0);
            if (bus.ram_we) begin nwe++; sa = bus.ram_a; sd = bus.ram_d; end
            if (bus.ram_re) begin nre++; sa = bus.ram_a; end
            if ((idx == 0) ? bus.ack_1 : bus.ack_0) other++;
            got = (idx == 0) ? bus.ack_0 : bus.ack_1;
        end
        check("ack_seen", 32'(got), 1);
        check("latency", cyc, w ? 2 : 2 + RD_LAT);
        check("we_cycles", nwe, w ? 1 : 0);
        check("re_cycles", nre, w ? 0 : 1);
        check("ram_a", 32'(sa), 32'(addr));
        if (w) check("ram_d", 32'(sd), 32'(dat));
        check("other_ack", other, 0);
        if (w) ref_mem[int'(addr)] = dat;
        else   ref_q[idx] = ref_rd(int'(addr));
        tb_last = idx;
        ref_stat[idx]++;
        check("q_0", 32'(bus.q_0), 32'(ref_q[0]));
        check("q_1", 32'(bus.q_1), 32'(ref_q[1]));
        bus.req_0 = 1'b0; bus.req_1 = 1'b0;
        @(posedge clk); @(negedge clk);
        check("ack_drop", 32'(bus.ack_0 | bus.ack_1), 0);
        check_stats("acc");
    endtask

    // Both requesters raise req on the same edge and hold it for n accesses.
    task automatic run_tie(input int n);
        int cyc, expw;
        logic got, wv;
        logic [15:0] wa;
        logic [7:0]  wd;
        @(posedge clk); #1;
        bus.req_0 = 1'b1; bus.req_1 = 1'b1;
        for (int k = 0; k < n; k++) begin
            expw = (tb_last == 1) ? 0 : 1;
            wv   = expw ? bus.we_1 : bus.we_0;
            wa   = expw ? bus.a_1  : bus.a_0;
            wd   = expw ? bus.d_1  : bus.d_0;
            cyc  = 0; got = 1'b0;
            while (!got && cyc < 20) begin
                @(posedge clk); cyc++;
                @(negedge clk);
                check("tie_strobe_excl", 32'(bus.ram_re & bus.ram_we), 0);
                got = bus.ack_0 | bus.ack_1;
            end
            check("tie_ack_seen", 32'(got), 1);
            check("tie_winner", 32'({bus.ack_1, bus.ack_0}), expw ? 2 : 1);
            if (k == 0) check("tie_latency", cyc, wv ? 2 : 2 + RD_LAT);
            else        check("tie_spacing", cyc, wv ? 3 : 3 + RD_LAT);
            if (wv) ref_mem[int'(wa)] = wd;
            else    ref_q[expw] = ref_rd(int'(wa));
            tb_last = expw;
            ref_stat[expw]++;
            check("tie_q_0", 32'(bus.q_0), 32'(ref_q[0]));
            check("tie_q_1", 32'(bus.q_1), 32'(ref_q[1]));
            if (k == n - 1) begin bus.req_0 = 1'b0; bus.req_1 = 1'b0; end
        end
        @(posedge clk); @(negedge clk);
        check("tie_ack_drop", 32'(bus.ack_0 | bus.ack_1), 0);
        check_stats("tie");
    endtask

    // Reset lands while a requester-0 read is in WAIT.
    task automatic abort_read(input logic [15:0] addr);
        int other;
        other = 0;
        @(posedge clk); #1;
        set_req(0, 1'b0, addr, 8'h00);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        ref_q[0] = '0; ref_q[1] = '0; tb_last = 1;
        ref_stat[0] = 0; ref_stat[1] = 0;
        check("abort_ack", 32'({bus.ack_1, bus.ack_0}), 0);
        check("abort_q_0", 32'(bus.q_0), 0);
        check("abort_q_1", 32'(bus.q_1), 0);
        check("abort_strobes", 32'({bus.ram_re, bus.ram_we}), 0);
        check("abort_ram_a", 32'(bus.ram_a), 0);
        check_stats("abort");
        rst = 1'b0; bus.req_0 = 1'b0;
        repeat (8) begin
            @(posedge clk); @(negedge clk);
            if (bus.ack_0 | bus.ack_1) other++;
        end
        check("abort_no_ack", other, 0);
    endtask

    function automatic logic [15:0] rand_addr();
        return ($urandom_range(0, 1) == 0) ? 16'($urandom_range(1, 7))
                                           : 16'hFF00 + 16'($urandom_range(0, 7));
    endfunction

    initial begin
        bus.req_0 = 1'b0; bus.we_0 = 1'b0; bus.a_0 = '0; bus.d_0 = '0;
        bus.req_1 = 1'b0; bus.we_1 = 1'b0; bus.a_1 = '0; bus.d_1 = '0;
        tb_last = 1;
        ref_q[0] = '0; ref_q[1] = '0;
        ref_stat[0] = 0; ref_stat[1] = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'({bus.ack_1, bus.ack_0}), 0);
        check("rst_q_0", 32'(bus.q_0), 0);
        check("rst_q_1", 32'(bus.q_1), 0);
        check("rst_ram_a", 32'(bus.ram_a), 0);
        check("rst_ram_d", 32'(bus.ram_d), 0);
        check("rst_strobes", 32'({bus.ram_re, bus.ram_we}), 0);
        check_stats("rst");
        rst = 1'b0;

        // First tie after reset: 0 writes 55 to 5, 1 reads 5 -> order 0,1,0,1.
        bus.we_0 = 1'b1; bus.a_0 = 16'd5; bus.d_0 = 8'd55;
        bus.we_1 = 1'b0; bus.a_1 = 16'd5; bus.d_1 = 8'd0;
        run_tie(4);

        do_access(0, 1'b1, 16'd0, 8'd100);
        do_access(0, 1'b0, 16'd0, 8'd0);
        do_access(1, 1'b0, 16'd0, 8'd0);
        do_access(1, 1'b1, 16'd32, 8'd30);
        do_access(0, 1'b0, 16'd32, 8'd0);
        do_access(0, 1'b1, 16'd40000, 8'hA5);
        do_access(1, 1'b0, 16'd40000, 8'd0);

        for (int i = 0; i < 24; i++)
            do_access(int'($urandom_range(0, 1)), 1'($urandom), rand_addr(), 8'($urandom));

        bus.we_0 = 1'($urandom); bus.a_0 = rand_addr(); bus.d_0 = 8'($urandom);
        bus.we_1 = 1'($urandom); bus.a_1 = rand_addr(); bus.d_1 = 8'($urandom);
        run_tie(6);

        abort_read(16'd32);
        do_access(0, 1'b0, 16'd0, 8'd0);
        check("post_abort_q_0", 32'(bus.q_0), 100);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the single-port 8-bit × 64K synchronous RAM in the LSU. Serialises read and write accesses from requester 0 (core LSU) and requester 1 (DMA/debug) onto the RAM's d/a/re/we/q pins. Runs a req/ack handshake on each side and captures read data after the RAM read latency.

Parameters:
RD_LAT, 1, RAM read latency in cycles from the issue edge to valid q; legal range 1..7
AW, 16, address width
DW, 8, data width

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
req_0  in  1  requester 0 request; held until ack_0
we_0  in  1  requester 0: 1 = write, 0 = read
a_0  in  AW  requester 0 address
d_0  in  DW  requester 0 write data
ack_0  out  1  requester 0 completion pulse, 1 cycle
q_0  out  DW  requester 0 read data; valid when ack_0 is high after a read
req_1, we_1, a_1, d_1, ack_1, q_1  same as above for requester 1
ram_a  out  AW  RAM address
ram_d  out  DW  RAM write data
ram_re  out  1  RAM read strobe
ram_we  out  1  RAM write strobe
ram_q  in  DW  RAM read data

Behaviour:
- Reset: state IDLE; ack_x = 0, q_x = 0, ram_a/ram_d = 0, ram_re/ram_we = 0; rr pointer gives requester 0 priority on the first tie.
- States: IDLE, ISSUE, WAIT, ACK. All outputs are registered.
- IDLE: if any req_x is high at an edge, pick a winner, latch its we/a/d and grant index, then go to ISSUE.
- Tie (both requesting): grant the requester that was not granted last; the pointer updates on every grant.
- ISSUE (1 cycle): ram_a and ram_d carry the latched values. ram_we = we and ram_re = !we. Never both strobes high.
  - Write: go to ACK.
  - Read: load the wait counter with RD_LAT and go to WAIT.
- WAIT: strobes low; the counter decrements each cycle. On the edge where the counter reaches 0, capture ram_q into q_<gnt> and go to ACK.
- ACK (1 cycle): ack_<gnt> = 1, then return to IDLE. q of the non-granted requester is unchanged.
- Latency from the edge that samples req to the ack-high cycle:
  - write: 2 cycles
  - read: 2 + RD_LAT cycles (3 at default)
- Handshake:
  - A requester holds req/we/a/d stable until it sees ack.
  - Inputs are latched only in IDLE, so changes after the grant are ignored.
  - If req is still high in the IDLE cycle after ACK, it is a new request and is arbitrated against the other requester (the rr pointer prevents starvation).
- Throughput: one access per 3 cycles (write) or 3 + RD_LAT cycles (read), because the IDLE cycle is mandatory.
- Address: full 16 bits pass through unmodified, e.g. 40000 = 0x9C40. No wrap or decode here.
- Reset mid-operation:
  - Aborts immediately; no ack is issued for the aborted access and q_x is cleared.
  - A write whose ISSUE cycle coincides with the reset edge still reaches the RAM, because ram_we was already high at that edge.
- req dropped before ack: a protocol violation. The access completes and ack still pulses.

Optional Feature:
RAM_ARB_STATS_EN
- Defined: adds outputs stat_0 and stat_1 (16 bits each), counting completed accesses (ACK cycles) per requester. They saturate at 0xFFFF and clear on rst.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header ram_arb_defs:
  - state encodings ST_IDLE = 0, ST_ISSUE = 1, ST_WAIT = 2, ST_ACK = 3
  - LAT_W = 3 (wait counter width)
  - default AW/DW
- One natural sub-module: rr_pick2. Combinational two-way round-robin picker with inputs req[1:0] and last; outputs gnt_valid and gnt_idx.

Test Plan:
- Requester 0 writes d=100 to a=0, then reads a=0 → ram_we high in exactly one cycle; ack_0 arrives 2 cycles after the write req edge; the read gives q_0 = 100 with ack_0 3 cycles after the req edge.
- Requester 1 writes 30 to a=32; requester 0 reads 32 → q_0 = 30; q_1 unchanged; ack_1 never pulses during requester 0's access.
- req_0 and req_1 rise on the same edge, both held for 4 accesses → grant order 0,1,0,1; no ack overlap; ram_re and ram_we never both high.
- Read of a=40000 with RD_LAT=3 → ram_a = 0x9C40 in ISSUE; ack 5 cycles after the req edge; q carries ram_q sampled 3 cycles after issue.
- rst asserted during the WAIT of a read → next cycle state IDLE, strobes 0, no ack, q_x = 0; a subsequent read of a=0 returns 100.
- With RAM_ARB_STATS_EN: 3 accesses by requester 0 and 2 by requester 1 → stat_0 = 3, stat_1 = 2; rst → both 0.
